// File: rtl/cpu6502_sprite_dma_pkg.sv
// cpu6502_dma_pkg: shared state encoding and default addresses for the sprite DMA engine.
`default_nettype none

package cpu6502_dma_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HALT  = 3'd1,
    ALIGN = 3'd2,
    READ  = 3'd3,
    WRITE = 3'd4
  } dma_state_t;

  localparam logic [15:0] DMA_TRIGGER_ADDR = 16'h4014;
  localparam logic [15:0] DMA_DEST_ADDR    = 16'h2004;
  localparam int          DMA_MAX_LENGTH   = 256;

endpackage

`default_nettype wire

// File: rtl/cpu6502_sprite_dma_if.sv
// cpu6502_sprite_dma_if: CPU snoop inputs and DMA bus-mux outputs of the sprite DMA engine.
`default_nettype none

interface cpu6502_sprite_dma_if;

  logic        clockEnable;
  logic [15:0] cpuAddress;
  logic [7:0]  cpuDataOut;
  logic        cpuWrite;
  logic [7:0]  busDataIn;
  logic        cpuReady;
  logic        busOwner;
  logic [15:0] busAddress;
  logic [7:0]  busDataOut;
  logic        busWrite;
  logic        busy;
`ifdef CPU6502_DMA_STALLCOUNT_EN
  logic        stallCountClear;
  logic [15:0] stallCount;

  modport master (
    output clockEnable, cpuAddress, cpuDataOut, cpuWrite, busDataIn, stallCountClear,
    input  cpuReady, busOwner, busAddress, busDataOut, busWrite, busy, stallCount
  );
  modport slave (
    input  clockEnable, cpuAddress, cpuDataOut, cpuWrite, busDataIn, stallCountClear,
    output cpuReady, busOwner, busAddress, busDataOut, busWrite, busy, stallCount
  );
`else
  modport master (
    output clockEnable, cpuAddress, cpuDataOut, cpuWrite, busDataIn,
    input  cpuReady, busOwner, busAddress, busDataOut, busWrite, busy
  );
  modport slave (
    input  clockEnable, cpuAddress, cpuDataOut, cpuWrite, busDataIn,
    output cpuReady, busOwner, busAddress, busDataOut, busWrite, busy
  );
`endif

endinterface

`default_nettype wire

// File: rtl/cpu6502_sprite_dma.sv
// cpu6502_sprite_dma: OAM-style page copy engine that halts the 6502 and drives the bus mux.
// Optional stall counter enabled by CPU6502_DMA_STALLCOUNT_EN.
`default_nettype none

module cpu6502_sprite_dma
  import cpu6502_dma_pkg::*;
#(
  parameter logic [15:0] TRIGGER_ADDR = DMA_TRIGGER_ADDR,
  parameter logic [15:0] DEST_ADDR    = DMA_DEST_ADDR,
  parameter int          LENGTH       = DMA_MAX_LENGTH
) (
  input  wire logic          clock,
  input  wire logic          reset,
  cpu6502_sprite_dma_if.slave bus
);

  localparam logic [7:0] LAST_INDEX = 8'(LENGTH - 1);

  dma_state_t  state, state_next;
  logic        parity;
  logic [7:0]  page, page_next;
  logic [7:0]  index, index_next;
  logic        busy_q, busy_next;
  logic        ready_q, ready_next;
  logic        owner_q, owner_next;
  logic [15:0] addr_q, addr_next;
  logic [7:0]  dout_q, dout_next;
  logic        write_q, write_next;

  always_comb begin
    state_next = state;
    page_next  = page;
    index_next = index;
    busy_next  = busy_q;
    ready_next = ready_q;
    owner_next = owner_q;
    addr_next  = addr_q;
    dout_next  = dout_q;
    write_next = 1'b0;
    case (state)
      IDLE: begin
        if (bus.cpuWrite && bus.cpuAddress == TRIGGER_ADDR) begin
          page_next  = bus.cpuDataOut;
          index_next = 8'd0;
          busy_next  = 1'b1;
          ready_next = 1'b0;
          state_next = HALT;
        end
      end
      HALT: begin
        // CPU write runs (RMW, interrupt pushes) cannot be halted; wait for a read cycle.
        if (!bus.cpuWrite) begin
          owner_next = 1'b1;
          addr_next  = {page, index};
          state_next = parity ? ALIGN : READ;
        end
      end
      ALIGN: begin
        addr_next  = {page, index};
        state_next = READ;
      end
      READ: begin
        // busDataOut doubles as the data latch for the following write.
        addr_next  = DEST_ADDR;
        dout_next  = bus.busDataIn;
        write_next = 1'b1;
        state_next = WRITE;
      end
      WRITE: begin
        if (index == LAST_INDEX) begin
          ready_next = 1'b1;
          owner_next = 1'b0;
          busy_next  = 1'b0;
          state_next = IDLE;
        end else begin
          index_next = index + 8'd1;
          addr_next  = {page, index + 8'd1};
          state_next = READ;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      parity  <= 1'b0;
      page    <= 8'd0;
      index   <= 8'd0;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
      owner_q <= 1'b0;
      addr_q  <= 16'd0;
      dout_q  <= 8'd0;
      write_q <= 1'b0;
    end else if (bus.clockEnable) begin
      state   <= state_next;
      parity  <= ~parity;
      page    <= page_next;
      index   <= index_next;
      busy_q  <= busy_next;
      ready_q <= ready_next;
      owner_q <= owner_next;
      addr_q  <= addr_next;
      dout_q  <= dout_next;
      write_q <= write_next;
    end
  end

  assign bus.cpuReady   = ready_q;
  assign bus.busOwner   = owner_q;
  assign bus.busAddress = addr_q;
  assign bus.busDataOut = dout_q;
  assign bus.busWrite   = write_q;
  assign bus.busy       = busy_q;

`ifdef CPU6502_DMA_STALLCOUNT_EN
  logic [15:0] stall_count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_count <= 16'd0;
    end else if (bus.clockEnable) begin
      if (bus.stallCountClear)
        stall_count <= 16'd0;
      else if (!ready_q && stall_count != 16'hFFFF)
        stall_count <= stall_count + 16'd1;
    end
  end

  assign bus.stallCount = stall_count;
`endif

endmodule

`default_nettype wire
